l3_req_arbiter: RTL and testbench
=================================

L3_REQ_ARBITER -- requirements
Module: l3_req_arbiter

Interface
REQ-001 Parameter: LAT, default 4, cycles between the issue cycle and the capture edge of the shared L3 datapath result; legal range 1..15.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  per-requester request level; bit i = requester i.
REQ-005 req_data  input  128  request words; bits [32i+31:32i] belong to requester i.
REQ-006 gnt  output  4  one-hot grant pulse, high for exactly the issue cycle.
REQ-007 l3_bus_out  output  32  word driven into the shared L3 datapath bus input.
REQ-008 l3_cache_in  input  32  shared L3 datapath result output.
REQ-009 rsp_valid  output  1  response strobe, one cycle.
REQ-010 rsp_id  output  2  requester index of the current response.
REQ-011 rsp_data  output  32  captured datapath result.
REQ-012 busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP; all outputs SHALL be registered.
REQ-014 IDLE: if req != 0, the arbiter SHALL select a winner, latch its index and req_data word, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-015 Arbitration SHALL be round-robin: priority order is last+1, last+2, last+3, last (mod 4), where last is the previously granted index.
REQ-016 ISSUE (exactly 1 cycle): gnt[id]=1, l3_bus_out=latched word; next state WAIT with the wait counter loaded to LAT-1.
REQ-017 Outside ISSUE, gnt SHALL be 0 and l3_bus_out SHALL be 32'h0.
REQ-018 WAIT SHALL last exactly LAT cycles, with the counter decrementing each cycle; on the edge ending the last WAIT cycle, rsp_data SHALL capture l3_cache_in and the state SHALL go to RESP.
REQ-019 RESP (exactly 1 cycle): rsp_valid=1, rsp_id=latched id, rsp_data=captured value.
REQ-020 RESP SHALL arbitrate exactly as IDLE: if req != 0 the next state is ISSUE (back-to-back), else IDLE.
REQ-021 Latency: with req first seen high in IDLE at cycle t, gnt is at t+1, rsp_valid is at t+2+LAT, and the minimum issue-to-issue spacing is LAT+2 cycles.
REQ-022 req and req_data are sampled only in IDLE/RESP; changes during ISSUE/WAIT SHALL be ignored. A requester SHALL drop req in the cycle after its gnt pulse unless it has a further word to send.
REQ-023 A requester whose req falls before it is selected SHALL receive no grant; no request queuing SHALL exist.
REQ-024 rsp_data and rsp_id SHALL hold their last values when rsp_valid=0.
REQ-025 busy = (state != IDLE).

Reset
REQ-026 Asynchronous assertion of rst_n=0, including mid-transaction, SHALL force state IDLE, gnt=0, l3_bus_out=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, wait counter=0, and last=3 (so requester 0 has first priority); an in-flight transaction is discarded with no response.
REQ-027 Deassertion of rst_n SHALL take effect at the next rising clk edge; the first arbitration decision is made in the first IDLE cycle after reset release.

Verification (LAT=4; bench models l3_cache_in = bus word delayed 4 cycles XOR 32'hA5A5A5A5)
REQ-028 Single request: req=4'b0100, data2=32'h0000_1234 at t -> gnt=4'b0100 at t+1; l3_bus_out=32'h0000_1234 at t+1 only; rsp_valid at t+6 with rsp_id=2, rsp_data=32'hA5A5_B791.
REQ-029 Round-robin: req=4'b1111 held high -> gnt sequence 0,1,2,3,0, with gnt pulses spaced 6 cycles apart and the rsp_id order matching.
REQ-030 Back-to-back: a new req is present during RESP -> ISSUE follows RESP directly, busy never drops, and rsp_valid/gnt never overlap.
REQ-031 Ignored inputs: req_data changes and a new req bit rise during WAIT -> l3_bus_out stays 0, the captured response is unaffected, and the new requester is granted only after RESP.
REQ-032 Mid-flight reset: rst_n pulsed low during WAIT -> all outputs are 0 immediately, no rsp_valid is issued, and after release req=4'b1001 grants requester 0 first.
REQ-033 Withdrawn request: req[1] pulses for 1 cycle while the block is busy -> no gnt[1] is issued at any time.

Source files
------------

// File: rtl/l3_req_arbiter_if.sv
// Request/response bundle between four requesters, the shared L3 datapath
// and the arbiter. The arbiter connects through the slave modport. The
// requesters and the datapath model connect through the master modport.
interface l3_req_arbiter_if;
   logic [3:0]   req;
   logic [127:0] req_data;
   logic [3:0]   gnt;
   logic [31:0]  l3_bus_out;
   logic [31:0]  l3_cache_in;
   logic         rsp_valid;
   logic [1:0]   rsp_id;
   logic [31:0]  rsp_data;
   logic         busy;

   modport master (
      output req, req_data, l3_cache_in,
      input  gnt, l3_bus_out, rsp_valid, rsp_id, rsp_data, busy
   );

   modport slave (
      input  req, req_data, l3_cache_in,
      output gnt, l3_bus_out, rsp_valid, rsp_id, rsp_data, busy
   );
endinterface

// File: rtl/l3_req_arbiter.sv
// Round-robin arbiter for four requesters sharing one fixed-latency L3
// datapath. Only one transaction is in flight at a time:
//    IDLE/RESP -> ISSUE (1 cycle) -> WAIT (LAT cycles) -> RESP (1 cycle)
// Every output comes straight from a register.
module l3_req_arbiter #(
   parameter int LAT = 4          // issue cycle to result capture edge, 1..15
) (
   input  logic            clk,
   input  logic            rst_n,
   l3_req_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t      state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic [1:0]  last_reg;
   logic [1:0]  sel_idx;
   logic [1:0]  cand;
   logic        sel_found;
   logic        issue_next;
   logic        capture;
   logic [31:0] word_arr [4];

   logic [3:0]  gnt_reg;
   logic [31:0] bus_reg;
   logic        rsp_valid_reg;
   logic [1:0]  rsp_id_reg;
   logic [31:0] rsp_data_reg;
   logic        busy_reg;

   // Split the packed request bus into one word per requester.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_word
         assign word_arr[gi] = bus.req_data[32*gi +: 32];
      end
   endgenerate

   // Round-robin pick. Scan last+1, last+2, last+3, last and keep the first active request.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = last_reg;
      cand      = '0;
      for (int k = 1; k <= 4; k++) begin
         cand = last_reg + 2'(k);
         if (!sel_found && bus.req[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   // Next-state and wait-counter logic. Requests are looked at only in IDLE and RESP.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE, RESP: state_next = sel_found ? ISSUE : IDLE;
         ISSUE: begin
            state_next = WAIT;
            cnt_next   = 4'(LAT - 1);
         end
         WAIT: begin
            if (cnt_reg == 4'd0) state_next = RESP;
            else                 cnt_next   = cnt_reg - 4'd1;
         end
         default: state_next = IDLE;
      endcase
   end

   assign issue_next = (state_next == ISSUE);
   assign capture    = (state_reg == WAIT) && (cnt_reg == 4'd0);

   // State register and wait counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= 4'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Registered outputs. Grant and bus word are set on the edge that enters
   // ISSUE, so they are high only for the ISSUE cycle. last_reg starts at 3
   // after reset, which gives requester 0 first priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_reg       <= 4'b0000;
         bus_reg       <= 32'h0;
         last_reg      <= 2'd3;
         rsp_valid_reg <= 1'b0;
         rsp_id_reg    <= 2'd0;
         rsp_data_reg  <= 32'h0;
         busy_reg      <= 1'b0;
      end else begin
         gnt_reg       <= issue_next ? (4'b0001 << sel_idx) : 4'b0000;
         bus_reg       <= issue_next ? word_arr[sel_idx] : 32'h0;
         if (issue_next) last_reg <= sel_idx;
         rsp_valid_reg <= capture;
         if (capture) begin
            rsp_data_reg <= bus.l3_cache_in;
            rsp_id_reg   <= last_reg;
         end
         busy_reg      <= (state_next != IDLE);
      end
   end

   assign bus.gnt        = gnt_reg;
   assign bus.l3_bus_out = bus_reg;
   assign bus.rsp_valid  = rsp_valid_reg;
   assign bus.rsp_id     = rsp_id_reg;
   assign bus.rsp_data   = rsp_data_reg;
   assign bus.busy       = busy_reg;

endmodule

// File: tb/tb_l3_req_arbiter.sv
// Directed bench for l3_req_arbiter with LAT=4. The L3 datapath model
// returns the bus word delayed by 4 cycles and XORed with 32'hA5A5A5A5.
module tb_l3_req_arbiter;
   localparam int          LAT = 4;
   localparam logic [31:0] K   = 32'hA5A5A5A5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   l3_req_arbiter_if bus ();

   l3_req_arbiter #(.LAT(LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Datapath model: 4-stage delay line on the bus word.
   logic [31:0] dly [4] = '{default: 32'h0};
   always @(posedge clk) begin
      dly[0] <= bus.l3_bus_out;
      for (int i = 1; i < 4; i++) dly[i] <= dly[i-1];
   end
   assign bus.l3_cache_in = dly[3] ^ K;

   int checks = 0;
   int errors = 0;

   // Background monitors.
   int   win_gnt1   = 0;
   int   gnt1_seen  = 0;
   int   overlap    = 0;
   always @(negedge clk) begin
      if (win_gnt1 != 0 && bus.gnt[1]) gnt1_seen++;
      if (rst_n && bus.rsp_valid && (bus.gnt != 4'b0000)) overlap++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [3:0]  gval  [8];
   int          gcyc  [8];
   logic [1:0]  rid   [8];
   logic [31:0] rdat  [8];
   int          ng, nr, busy_drop, rv;
   logic [31:0] words [4];
   int          exp_idx [5];

   initial begin
      bus.req      = 4'b0000;
      bus.req_data = 128'h0;
      exp_idx      = '{0, 1, 2, 3, 0};

      // ---------------- reset state ----------------
      #12;
      chk("rst_gnt",       {28'h0, bus.gnt},       32'h0);
      chk("rst_bus",       bus.l3_bus_out,         32'h0);
      chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
      chk("rst_rsp_id",    {30'h0, bus.rsp_id},    32'h0);
      chk("rst_rsp_data",  bus.rsp_data,           32'h0);
      chk("rst_busy",      {31'h0, bus.busy},      32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      step();

      // ---------------- single request, requester 2 ----------------
      bus.req_data[95:64] = 32'h0000_1234;
      bus.req             = 4'b0100;
      chk("t1_idle_busy", {31'h0, bus.busy}, 32'h0);
      step();                                     // t+1
      chk("t1_gnt",  {28'h0, bus.gnt}, 32'h4);
      chk("t1_bus",  bus.l3_bus_out,   32'h0000_1234);
      chk("t1_busy", {31'h0, bus.busy}, 32'h1);
      bus.req = 4'b0000;
      step();                                     // t+2
      chk("t1_gnt_off", {28'h0, bus.gnt}, 32'h0);
      chk("t1_bus_off", bus.l3_bus_out,   32'h0);
      repeat (3) begin
         step();                                  // t+3..t+5
         chk("t1_no_early_rsp", {31'h0, bus.rsp_valid}, 32'h0);
      end
      step();                                     // t+6
      chk("t1_rsp_valid", {31'h0, bus.rsp_valid}, 32'h1);
      chk("t1_rsp_id",    {30'h0, bus.rsp_id},    32'h2);
      chk("t1_rsp_data",  bus.rsp_data,           32'hA5A5_B791);
      step();                                     // t+7
      chk("t1_rsp_drop", {31'h0, bus.rsp_valid}, 32'h0);
      chk("t1_hold_id",  {30'h0, bus.rsp_id},    32'h2);
      chk("t1_hold_dat", bus.rsp_data,           32'hA5A5_B791);
      chk("t1_idle",     {31'h0, bus.busy},      32'h0);

      // ---------------- ignored inputs and withdrawn request ----------------
      win_gnt1     = 1;
      bus.req_data = {32'h7777_0003, 32'h0, 32'h0, 32'hCAFE_0001};
      bus.req      = 4'b0001;
      step();                                     // t+1
      chk("t2_gnt", {28'h0, bus.gnt}, 32'h1);
      chk("t2_bus", bus.l3_bus_out,   32'hCAFE_0001);
      bus.req = 4'b0000;
      step();                                     // t+2
      step();                                     // t+3
      bus.req_data[31:0] = 32'hDEAD_BEEF;
      bus.req            = 4'b0010;               // 1-cycle pulse from requester 1
      chk("t2_bus_wait3", bus.l3_bus_out, 32'h0);
      step();                                     // t+4
      bus.req = 4'b1000;                          // requester 3 rises during WAIT
      chk("t2_bus_wait4", bus.l3_bus_out,   32'h0);
      chk("t2_gnt_wait4", {28'h0, bus.gnt}, 32'h0);
      step();                                     // t+5
      chk("t2_bus_wait5", bus.l3_bus_out, 32'h0);
      step();                                     // t+6
      chk("t2_rsp_valid", {31'h0, bus.rsp_valid}, 32'h1);
      chk("t2_rsp_id",    {30'h0, bus.rsp_id},    32'h0);
      chk("t2_rsp_data",  bus.rsp_data,           32'h6F5B_A5A4);
      chk("t2_rsp_nogt",  {28'h0, bus.gnt},       32'h0);
      step();                                     // t+7
      chk("t2_gnt3",      {28'h0, bus.gnt},       32'h8);
      chk("t2_bus3",      bus.l3_bus_out,         32'h7777_0003);
      chk("t2_busy_b2b",  {31'h0, bus.busy},      32'h1);
      bus.req = 4'b0000;
      repeat (4) step();                          // t+11
      step();                                     // t+12
      chk("t2_rsp3_valid", {31'h0, bus.rsp_valid}, 32'h1);
      chk("t2_rsp3_id",    {30'h0, bus.rsp_id},    32'h3);
      chk("t2_rsp3_data",  bus.rsp_data,           32'hD2D2_A5A6);
      step();
      chk("t2_idle", {31'h0, bus.busy}, 32'h0);
      win_gnt1 = 0;
      chk("t2_no_gnt1", gnt1_seen, 32'd0);

      // ---------------- mid-flight reset ----------------
      bus.req_data[95:64] = 32'h0BAD_0002;
      bus.req             = 4'b0100;
      step();                                     // t+1
      chk("t3_gnt", {28'h0, bus.gnt}, 32'h4);
      bus.req = 4'b0000;
      step();                                     // t+2
      step();                                     // t+3, in WAIT
      #2 rst_n = 1'b0;
      #1;
      chk("t3_rst_gnt",       {28'h0, bus.gnt},       32'h0);
      chk("t3_rst_bus",       bus.l3_bus_out,         32'h0);
      chk("t3_rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
      chk("t3_rst_rsp_id",    {30'h0, bus.rsp_id},    32'h0);
      chk("t3_rst_rsp_data",  bus.rsp_data,           32'h0);
      chk("t3_rst_busy",      {31'h0, bus.busy},      32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      rv = 0;
      repeat (8) begin
         step();
         if (bus.rsp_valid) rv++;
      end
      chk("t3_no_stale_rsp", rv, 32'd0);

      // ---------------- round robin with back-to-back issue ----------------
      words = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
      bus.req_data = {words[3], words[2], words[1], words[0]};
      bus.req      = 4'b1001;
      ng = 0; nr = 0; busy_drop = 0;
      overlap = 0;
      for (int c = 1; c <= 34; c++) begin
         step();
         if (bus.gnt != 4'b0000 && ng < 8) begin
            gval[ng] = bus.gnt;
            gcyc[ng] = c;
            ng++;
            if (ng == 1) bus.req = 4'b1111;
            if (ng == 5) bus.req = 4'b0000;
         end
         if (bus.rsp_valid && nr < 8) begin
            rid[nr]  = bus.rsp_id;
            rdat[nr] = bus.rsp_data;
            nr++;
         end
         if (c <= 30 && !bus.busy) busy_drop++;
      end
      chk("rr_gnt_count", ng, 32'd5);
      chk("rr_rsp_count", nr, 32'd5);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("rr_gnt%0d", k),  {28'h0, gval[k]}, 32'(4'b0001 << exp_idx[k]));
         chk($sformatf("rr_cyc%0d", k),  gcyc[k], 32'(1 + 6*k));
         chk($sformatf("rr_id%0d", k),   {30'h0, rid[k]}, 32'(exp_idx[k]));
         chk($sformatf("rr_data%0d", k), rdat[k], words[exp_idx[k]] ^ K);
      end
      chk("rr_busy_held", busy_drop, 32'd0);
      chk("rr_no_overlap", overlap, 32'd0);
      chk("rr_end_idle", {31'h0, bus.busy}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
